// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port, fixed-latency memory between the instruction
//   fetch (IF) requester and the data load/store (D) requester. Each access
//   runs through IDLE -> BUSY (MEM_LATENCY cycles) -> RESP (one cycle). The
//   owner of the access gets a one-cycle valid pulse in RESP.
//
//   Optional build macro: ARB_RR_EN
//     defined   - round-robin between IF and D on simultaneous requests
//     undefined - fixed priority, D wins over IF
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   if_req, if_addr            fetch request / byte address
//   if_valid                   fetch response pulse (data on rsp_rdata)
//   d_req, d_we, d_addr,
//   d_wdata                    load/store request, write enable, address, data
//   d_valid, d_err             load/store response pulse, misalignment error
//   rsp_rdata                  response data shared by both requesters
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata       memory interface
//   busy                       FSM is not in IDLE
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_valid,
    output logic              d_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    state_t            state_q, state_d;
    logic              own_d_q;   // 1 = access belongs to D, 0 = IF
    logic              we_q;
    logic              mis_q;     // misaligned D access: suppress memory, flag error
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        cnt_q;
    logic [DATA_W-1:0] rdata_q;
    logic              gnt_any;
    logic              gnt_d;

    assign gnt_any = if_req | d_req;

`ifdef ARB_RR_EN
    logic last_gnt_d_q;  // 1 = last granted access went to D

    // On a tie the requester that did not win last time is served.
    assign gnt_d = d_req & (~if_req | ~last_gnt_d_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_d_q <= 1'b1;
        end else if (state_q == IDLE && gnt_any) begin
            last_gnt_d_q <= gnt_d;
        end
    end
`else
    assign gnt_d = d_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_any) state_d = BUSY;
            BUSY:    if (cnt_q == 4'd0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latches and latency counter; requesters may change their
    // inputs during BUSY without affecting the access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_d_q <= 1'b0;
            we_q    <= 1'b0;
            mis_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
        end else begin
            if (state_q == IDLE && gnt_any) begin
                own_d_q <= gnt_d;
                we_q    <= gnt_d & d_we;
                mis_q   <= gnt_d & (d_addr[1:0] != 2'b00);
                addr_q  <= gnt_d ? d_addr : if_addr;
                wdata_q <= d_wdata;
                cnt_q   <= CNT_INIT;
            end else if (state_q == BUSY) begin
                if (cnt_q != 4'd0) begin
                    cnt_q <= cnt_q - 4'd1;
                end else if (!we_q && !mis_q) begin
                    rdata_q <= mem_rdata;
                end
            end
        end
    end

    always_comb begin
        busy     = 1'b0;
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        if_valid = 1'b0;
        d_valid  = 1'b0;
        d_err    = 1'b0;
        case (state_q)
            BUSY: begin
                busy   = 1'b1;
                mem_en = ~mis_q;
                mem_we = ~mis_q & own_d_q & we_q;
            end
            RESP: begin
                busy     = 1'b1;
                if_valid = ~own_d_q;
                d_valid  = own_d_q;
                d_err    = own_d_q & mis_q;
            end
            default: ;
        endcase
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic        if_valid, d_valid, d_err, mem_en, mem_we, busy;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;

    // second instance, MEM_LATENCY = 1
    logic        if_req1 = 1'b0;
    logic        if_valid1, d_valid1, d_err1, mem_en1, mem_we1, busy1;
    logic [31:0] rsp_rdata1, mem_addr1, mem_wdata1;
    logic [31:0] mem_rdata1 = 32'hCAFEF00D;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT)) u0 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_valid(d_valid), .d_err(d_err), .rsp_rdata(rsp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req1), .if_addr(32'h80), .if_valid(if_valid1),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
        .d_valid(d_valid1), .d_err(d_err1), .rsp_rdata(rsp_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy1)
    );

    // Memory stub: combinational read, write on the clock edge.
    logic [31:0] mem [0:255];
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (!rst_n) begin
            mem[16] <= 32'h2008000A;   // 0x40
            mem[65] <= 32'h11112222;   // 0x104
        end else if (mem_en && mem_we) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        else
            n_pass++;
    endtask

    // Transaction-level model: an access occupies LAT busy cycles followed by
    // one response cycle, counted by the age of the access in clock edges.
    logic        m_act, m_own_d, m_we, m_mis, m_last_d;
    int          m_age;
    logic [31:0] m_addr, m_wdata, m_rsp;
    logic [31:0] exp_mem [int];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act = 0; m_age = 0; m_own_d = 0; m_we = 0; m_mis = 0;
            m_addr = 0; m_wdata = 0; m_rsp = 0; m_last_d = 1;
            exp_mem[16] = 32'h2008000A;
            exp_mem[65] = 32'h11112222;
        end else if (m_act) begin
            m_age++;
            if (m_age == LAT && !m_we && !m_mis) m_rsp = exp_mem[int'(m_addr[9:2])];
            if (m_age == LAT + 1) m_act = 0;
        end else if (if_req || d_req) begin
`ifdef ARB_RR_EN
            m_own_d = d_req && (!if_req || !m_last_d);
`else
            m_own_d = d_req;
`endif
            m_last_d = m_own_d;
            m_act   = 1;
            m_age   = 0;
            m_addr  = m_own_d ? d_addr : if_addr;
            m_we    = m_own_d && d_we;
            m_mis   = m_own_d && (d_addr[1:0] != 2'b00);
            m_wdata = d_wdata;
            if (m_we && !m_mis) exp_mem[int'(m_addr[9:2])] = m_wdata;
        end
    end

    always @(negedge clk) begin
        logic e_busy, e_en, e_resp;
        e_busy = m_act;
        e_en   = m_act && m_age < LAT && !m_mis;
        e_resp = m_act && m_age == LAT;
        chk("busy", 32'(busy), 32'(e_busy));
        chk("mem_en", 32'(mem_en), 32'(e_en));
        chk("mem_we", 32'(mem_we), 32'(e_en && m_we));
        chk("if_valid", 32'(if_valid), 32'(e_resp && !m_own_d));
        chk("d_valid", 32'(d_valid), 32'(e_resp && m_own_d));
        chk("d_err", 32'(d_err), 32'(e_resp && m_own_d && m_mis));
        chk("rsp_rdata", rsp_rdata, m_rsp);
        if (e_en) chk("mem_addr", mem_addr, m_addr);
        if (e_en && m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int td, ti, nv, en_seen, idle_cnt;
        int tv[$];

        // reset state
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_rsp", rsp_rdata, 32'd0);
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // T1 lone fetch
        if_req = 1; if_addr = 32'h40;
        step();
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_mem_addr", mem_addr, 32'h40);
        step();
        chk("t1_ifv_early", 32'(if_valid), 32'd0);
        step();
        chk("t1_ifv", 32'(if_valid), 32'd1);
        chk("t1_rsp", rsp_rdata, 32'h2008000A);
        chk("t1_dv", 32'(d_valid), 32'd0);
        if_req = 0;
        step();
        chk("t1_idle", 32'(busy), 32'd0);

        // T2 aligned store
        d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
        step();
        chk("t2_en1", 32'({mem_en, mem_we}), 32'd3);
        chk("t2_addr", mem_addr, 32'h100);
        step();
        chk("t2_en2", 32'({mem_en, mem_we}), 32'd3);
        step();
        chk("t2_dv", 32'({d_valid, d_err, mem_en}), 32'b100);
        d_req = 0; d_we = 0;
        step();
        // read back the stored word
        d_req = 1; d_addr = 32'h100;
        td = -1;
        for (int c = 0; c < 10 && td < 0; c++) begin
            step();
            if (d_valid) td = c;
        end
        chk("t2_rd_seen", 32'(td >= 0), 32'd1);
        chk("t2_rd", rsp_rdata, 32'hDEADBEEF);
        d_req = 0;
        step();

        // T3 simultaneous requests
        d_req = 1; d_we = 0; d_addr = 32'h104;
        if_req = 1; if_addr = 32'h40;
        td = -1; ti = -1;
        for (int c = 0; c < 20 && (td < 0 || ti < 0); c++) begin
            step();
            if (d_valid)  begin td = c; d_req = 0; end
            if (if_valid) begin ti = c; if_req = 0; end
        end
        chk("t3_both_seen", 32'(td >= 0 && ti >= 0), 32'd1);
`ifdef ARB_RR_EN
        chk("t3_order", 32'(td - ti), 32'd4);
`else
        chk("t3_order", 32'(ti - td), 32'd4);
`endif
        step();

        // T4 misaligned store
        d_req = 1; d_we = 1; d_addr = 32'h102; d_wdata = 32'h55555555;
        en_seen = 0;
        step();
        if (mem_en) en_seen++;
        step();
        if (mem_en) en_seen++;
        step();
        chk("t4_en", 32'(en_seen), 32'd0);
        chk("t4_dv_err", 32'({d_valid, d_err}), 32'b11);
        d_req = 0; d_we = 0;
        step();
        chk("t4_mem", mem[64], 32'hDEADBEEF);

        // T5 reset mid-BUSY
        if_req = 1; if_addr = 32'h40;
        step();
        chk("t5_busy", 32'(busy), 32'd1);
        rst_n = 0;
        #1;
        chk("t5_async", 32'({busy, mem_en, if_valid, d_valid}), 32'd0);
        if_req = 0;
        step();
        step();
        rst_n = 1;
        nv = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (if_valid || d_valid) nv++;
        end
        chk("t5_no_valid", 32'(nv), 32'd0);

        // T6 MEM_LATENCY=1, fetch held high
        if_req1 = 1;
        idle_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (if_valid1) tv.push_back(c);
            if (tv.size() > 0 && tv.size() < 3 && !busy1) idle_cnt++;
        end
        if_req1 = 0;
        chk("t6_pulses", 32'(tv.size() >= 3), 32'd1);
        if (tv.size() >= 3) begin
            chk("t6_gap1", 32'(tv[1] - tv[0]), 32'd3);
            chk("t6_gap2", 32'(tv[2] - tv[1]), 32'd3);
        end
        chk("t6_idle", 32'(idle_cnt), 32'd2);
        chk("t6_rsp", rsp_rdata1, 32'hCAFEF00D);
        chk("t6_dv", 32'({d_valid1, d_err1}), 32'd0);

        step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
